// File: rtl/wb_stage.sv
// Write-back pipeline stage: registers MEM results, extracts big-endian load data,
// picks the write-back source and drives the register file write port and retire counter.
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_valid,
   input  logic        in_reg_write,
   input  logic        in_mem_to_reg,
   input  logic        in_link,
   input  logic [2:0]  in_load_type,
   input  logic [4:0]  in_write_reg,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_mem_rdata,
   input  logic [31:0] in_pc_plus8,
   output logic        RegWrite,
   output logic [4:0]  Write_reg,
   output logic [31:0] Data,
   output logic        wb_valid,
   output logic        misalign_err,
   output logic [31:0] retired_count
);

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LHU = 3'b010;
   localparam logic [2:0] LD_LB  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;

   logic [1:0]  off;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadData;
   logic        misaligned;
   logic [31:0] wbData;

   logic        valid_q,     valid_d;
   logic        regWrite_q,  regWrite_d;
   logic        misalign_q,  misalign_d;
   logic [4:0]  writeReg_q,  writeReg_d;
   logic [31:0] data_q,      data_d;
   logic [31:0] count_q,     count_d;

   assign off = in_alu_result[1:0];

   // Byte 0 is the most significant byte of the word (big-endian).
   always_comb begin
      loadByte   = in_mem_rdata[31:24];
      loadHalf   = off[1] ? in_mem_rdata[15:0] : in_mem_rdata[31:16];
      loadData   = in_mem_rdata;
      misaligned = 1'b0;
      case (off)
         2'd0:    loadByte = in_mem_rdata[31:24];
         2'd1:    loadByte = in_mem_rdata[23:16];
         2'd2:    loadByte = in_mem_rdata[15:8];
         default: loadByte = in_mem_rdata[7:0];
      endcase
      case (in_load_type)
         LD_LB: loadData = {{24{loadByte[7]}}, loadByte};
         LD_LBU: loadData = {24'h000000, loadByte};
         LD_LH: begin
            loadData   = {{16{loadHalf[15]}}, loadHalf};
            misaligned = off[0];
         end
         LD_LHU: begin
            loadData   = {16'h0000, loadHalf};
            misaligned = off[0];
         end
         default: begin
            loadData   = in_mem_rdata;
            misaligned = (off != 2'd0);
         end
      endcase
      if (!in_mem_to_reg || in_link) begin
         misaligned = 1'b0;
      end
      if (in_link) begin
         wbData = in_pc_plus8;
      end else if (in_mem_to_reg) begin
         wbData = loadData;
      end else begin
         wbData = in_alu_result;
      end
   end

   // Flush beats stall; a flushed bubble keeps the old index/data but never writes.
   always_comb begin
      valid_d    = valid_q;
      regWrite_d = regWrite_q;
      misalign_d = misalign_q;
      writeReg_d = writeReg_q;
      data_d     = data_q;
      count_d    = count_q;
      if (flush) begin
         valid_d    = 1'b0;
         regWrite_d = 1'b0;
         misalign_d = 1'b0;
      end else if (!stall) begin
         valid_d    = in_valid;
         regWrite_d = in_reg_write;
         misalign_d = misaligned;
         writeReg_d = in_write_reg;
         data_d     = wbData;
         if (in_valid && !misaligned) begin
            count_d = count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         regWrite_q <= 1'b0;
         misalign_q <= 1'b0;
         writeReg_q <= 5'd0;
         data_q     <= 32'd0;
         count_q    <= 32'd0;
      end else begin
         valid_q    <= valid_d;
         regWrite_q <= regWrite_d;
         misalign_q <= misalign_d;
         writeReg_q <= writeReg_d;
         data_q     <= data_d;
         count_q    <= count_d;
      end
   end

   assign wb_valid      = valid_q;
   assign misalign_err  = valid_q & misalign_q;
   assign RegWrite      = valid_q & regWrite_q & (writeReg_q != 5'd0) & ~misalign_q;
   assign Write_reg     = writeReg_q;
   assign Data          = data_q;
   assign retired_count = count_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back pipeline stage of the MIPS datapath. Captures MEM-stage results on the clock edge, extracts and extends load data, selects the write-back source (ALU result, load data, or link address) and drives the register file write port (RegWrite, Write_reg, Data) from flops. The same outputs serve as the WB-stage forwarding source. The stage also keeps a retired-instruction counter.

## Interface
- No parameters. Data width is fixed at 32, register index width at 5.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold current WB contents
- flush  in  1  replace next WB contents with a bubble
- in_valid  in  1  MEM stage holds a real instruction
- in_reg_write  in  1  instruction writes a GPR
- in_mem_to_reg  in  1  write-back source is load data
- in_link  in  1  write-back source is in_pc_plus8 (jal/jalr); overrides in_mem_to_reg
- in_load_type  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw
- in_write_reg  in  5  destination GPR index
- in_alu_result  in  32  ALU result; bits [1:0] are the load byte offset
- in_mem_rdata  in  32  raw aligned data-memory word
- in_pc_plus8  in  32  link address
- RegWrite  out  1  register file write enable
- Write_reg  out  5  register file write index
- Data  out  32  register file write data
- wb_valid  out  1  WB holds a real instruction
- misalign_err  out  1  WB instruction was a misaligned load (write suppressed)
- retired_count  out  32  number of instructions retired

## Operation
- Load extraction is big-endian and computed before the flops. With off = in_alu_result[1:0]:
  - lb/lbu: byte off 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. lb sign-extends; lbu zero-extends.
  - lh/lhu: off 0 = [31:16], off 2 = [15:0]. lh sign-extends; lhu zero-extends.
  - lw: the full word.
- Misaligned load: in_mem_to_reg=1, in_link=0, and either lh/lhu with off[0]=1 or lw with off≠0.
- Source select: in_link → in_pc_plus8; else in_mem_to_reg → extracted load data; else in_alu_result.
- RegWrite = wb_valid & reg_write_q & (Write_reg≠0) & !misalign_err. A write to $0 never asserts RegWrite.
- Data and Write_reg are still driven with the captured values when RegWrite=0.
- misalign_err = wb_valid & misaligned_q.
- Edge update priority, highest first:
  - flush → bubble: wb_valid=0, RegWrite=0, misalign_err=0. Write_reg/Data are don't-care but are held at their previous values.
  - stall → all flops hold. RegWrite stays as-is; re-writing the same value is harmless.
  - otherwise → capture inputs; wb_valid ← in_valid.
- retired_count increments by 1 on each edge that captures an entry with in_valid=1 and no misalignment, with flush=0 and stall=0.
  - Wraps 0xFFFFFFFF → 0x00000000.
  - Not incremented during stall. The held instruction is not double-counted.

## Timing
- Latency 1 cycle: inputs sampled at edge N are visible on all outputs after edge N. No combinational path from any input to any output.
- Reset (asynchronous, takes effect immediately): RegWrite=0, Write_reg=0, Data=0, wb_valid=0, misalign_err=0, retired_count=0.
- Reset mid-operation discards the WB entry. The register file sees no write in the reset cycle.
- Release of reset is synchronised externally. The first capture happens at the first edge with rst=0.
- flush and stall both high: flush wins, and the count does not increment.
- Back-to-back valid inputs with no stall: one capture per cycle, throughput 1 instruction/cycle.

## Test plan
- Reset: assert rst mid-stream with RegWrite=1 → all outputs 0 immediately, and retired_count=0.
- ALU write then $0 write:
  - in_reg_write=1, in_write_reg=8, in_alu_result=0x0000_1234 → next cycle RegWrite=1, Write_reg=8, Data=0x0000_1234, count+1.
  - Same with in_write_reg=0 → RegWrite=0, count+1.
- Loads on in_mem_rdata=0x80F1_7F02:
  - lb off 1 → Data=0xFFFF_FFF1
  - lbu off 1 → Data=0x0000_00F1
  - lh off 0 → Data=0xFFFF_80F1
  - lhu off 2 → Data=0x0000_7F02
  - lw off 0 → Data=0x80F1_7F02
- Misaligned: lh off 1, then lw off 2 → misalign_err=1 and RegWrite=0 each cycle, count unchanged.
- Link: in_link=1, in_mem_to_reg=1, in_write_reg=31, in_pc_plus8=0x0040_0010 → Data=0x0040_0010, Write_reg=31, RegWrite=1.
- Stall, flush, and wrap:
  - Stall for 3 cycles with changing inputs → outputs frozen, count unchanged.
  - stall=1 and flush=1 together → wb_valid=0, RegWrite=0.
  - Force the count to 0xFFFF_FFFF by retiring 2^32−1 instructions, or a shortened bench via a hierarchical force; one more retirement → 0.
